sd_cmd_seq: RTL and testbench

SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

---
 rtl/sd_pkg.sv | 59 +++++
 rtl/sd_cmd_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_sd_cmd_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - Shared types and constants for the SD card command sequencer
// Purpose: sequencer state enum (its encoding is the card_stat code), the
// handshake phase used inside every command state, SD command indices and
// the card_type encoding.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_CMD0   = 4'd0,
    ST_CMD8   = 4'd1,
    ST_CMD55  = 4'd2,
    ST_ACMD41 = 4'd3,
    ST_CMD2   = 4'd4,
    ST_CMD3   = 4'd5,
    ST_CMD7   = 4'd6,
    ST_CMD16  = 4'd7,
    ST_IDLE   = 4'd8,
    ST_CMD17  = 4'd9,
    ST_READ   = 4'd10,
    ST_ERROR  = 4'd11
  } state_t;

  // SETUP loads the request registers, ISSUE pulses cmd_start, WAIT samples
  // status on cmd_done.
  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_ISSUE = 2'd1,
    PH_WAIT  = 2'd2
  } phase_t;

  localparam logic [5:0] CMD_GO_IDLE       = 6'd0;
  localparam logic [5:0] CMD_ALL_SEND_CID  = 6'd2;
  localparam logic [5:0] CMD_SEND_RCA      = 6'd3;
  localparam logic [5:0] CMD_SELECT        = 6'd7;
  localparam logic [5:0] CMD_SEND_IF_COND  = 6'd8;
  localparam logic [5:0] CMD_SET_BLOCKLEN  = 6'd16;
  localparam logic [5:0] CMD_READ_SINGLE   = 6'd17;
  localparam logic [5:0] ACMD_SD_OP_COND   = 6'd41;
  localparam logic [5:0] CMD_APP_CMD       = 6'd55;

  localparam logic [1:0] CT_UNKNOWN = 2'd0;
  localparam logic [1:0] CT_SDV1    = 2'd1;
  localparam logic [1:0] CT_SDV2_SC = 2'd2;
  localparam logic [1:0] CT_SDHC    = 2'd3;

  function automatic logic [5:0] cmd_index(input state_t s);
    case (s)
      ST_CMD8:   return CMD_SEND_IF_COND;
      ST_CMD55:  return CMD_APP_CMD;
      ST_ACMD41: return ACMD_SD_OP_COND;
      ST_CMD2:   return CMD_ALL_SEND_CID;
      ST_CMD3:   return CMD_SEND_RCA;
      ST_CMD7:   return CMD_SELECT;
      ST_CMD16:  return CMD_SET_BLOCKLEN;
      ST_CMD17:  return CMD_READ_SINGLE;
      default:   return CMD_GO_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sd_cmd_seq.sv
// rtl/sd_cmd_seq.sv - SD card init and single-block read command sequencer
// Purpose: walks the card through identification (CMD0/8/55/41/2/3/7/16),
// then serves single-sector reads (CMD17 + data receiver) from IDLE.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   rstart, rsector                read request pulse and sector number
//   rbusy, rdone, rerr             busy level, read-complete pulse, error flag
//   card_type, card_stat           detected card type, current state code
//   cmd_clkdiv .. cmd_arg          request to the command engine
//   cmd_busy .. cmd_resparg        status from the command engine
//   dat_start, dat_done, dat_err   data receiver handshake
module sd_cmd_seq
  import sd_pkg::*;
#(
  parameter logic [15:0] SLOWDIV = 16'd63,
  parameter logic [15:0] FASTDIV = 16'd1,
  parameter logic [15:0] RETRIES = 16'd4095
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rstart,
  input  logic [31:0] rsector,
  output logic        rbusy,
  output logic        rdone,
  output logic        rerr,
  output logic [1:0]  card_type,
  output logic [3:0]  card_stat,
  output logic [15:0] cmd_clkdiv,
  output logic        cmd_start,
  output logic [15:0] cmd_precnt,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic        cmd_syntaxe,
  input  logic [31:0] cmd_resparg,
  output logic        dat_start,
  input  logic        dat_done,
  input  logic        dat_err
);

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic        start_n, rbusy_n, rdone_n, rerr_n, dat_start_n;
  logic [5:0]  idx_n;
  logic [31:0] arg_n, sector, sector_n;
  logic [15:0] precnt_n, clkdiv_n, rca, rca_n, retry_cnt, retry_n, retry_inc;
  logic [1:0]  card_type_n;
  logic        v2, v2_n, ccs, ccs_n, do_retry;
  logic        ok, fin, unused_resp;

  assign ok          = cmd_done & ~cmd_timeout & ~cmd_syntaxe;
  // cmd_start is still high in the first WAIT cycle; the engine cannot have
  // finished the command it is only now being handed.
  assign fin         = (phase == PH_WAIT) && !cmd_start && cmd_done;
  assign retry_inc   = retry_cnt + 16'd1;
  assign card_stat   = state;
  assign unused_resp = ^cmd_resparg[15:12];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_CMD0;
      phase      <= PH_SETUP;
      cmd_start  <= 1'b0;
      cmd_idx    <= '0;
      cmd_arg    <= '0;
      cmd_precnt <= '0;
      cmd_clkdiv <= SLOWDIV;
      rbusy      <= 1'b1;
      rdone      <= 1'b0;
      rerr       <= 1'b0;
      dat_start  <= 1'b0;
      card_type  <= CT_UNKNOWN;
      v2         <= 1'b0;
      ccs        <= 1'b0;
      rca        <= '0;
      retry_cnt  <= '0;
      sector     <= '0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      cmd_start  <= start_n;
      cmd_idx    <= idx_n;
      cmd_arg    <= arg_n;
      cmd_precnt <= precnt_n;
      cmd_clkdiv <= clkdiv_n;
      rbusy      <= rbusy_n;
      rdone      <= rdone_n;
      rerr       <= rerr_n;
      dat_start  <= dat_start_n;
      card_type  <= card_type_n;
      v2         <= v2_n;
      ccs        <= ccs_n;
      rca        <= rca_n;
      retry_cnt  <= retry_n;
      sector     <= sector_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    start_n     = 1'b0;
    idx_n       = cmd_idx;
    arg_n       = cmd_arg;
    precnt_n    = cmd_precnt;
    clkdiv_n    = cmd_clkdiv;
    rdone_n     = 1'b0;
    rerr_n      = 1'b0;
    dat_start_n = 1'b0;
    card_type_n = card_type;
    v2_n        = v2;
    ccs_n       = ccs;
    rca_n       = rca;
    retry_n     = retry_cnt;
    sector_n    = sector;
    do_retry    = 1'b0;

    case (state)
      ST_IDLE: begin
        // A request landing in the rdone cycle is dropped.
        if (rstart && !rdone) begin
          sector_n = rsector;
          state_n  = ST_CMD17;
        end
      end
      ST_READ: begin
        if (dat_done || dat_err) begin
          rdone_n = 1'b1;
          rerr_n  = dat_err;
          state_n = ST_IDLE;
        end
      end
      ST_ERROR: ;
      default: begin
        case (phase)
          PH_SETUP: begin
            idx_n    = cmd_index(state);
            precnt_n = (state == ST_CMD0) ? 16'd96 : 16'd8;
            case (state)
              ST_CMD8:   arg_n = 32'h0000_01AA;
              ST_ACMD41: arg_n = v2 ? 32'h4010_0000 : 32'h0010_0000;
              ST_CMD7:   arg_n = {rca, 16'h0000};
              ST_CMD16:  arg_n = 32'd512;
              // Standard-capacity cards are byte addressed.
              ST_CMD17:  arg_n = ccs ? sector : {sector[22:0], 9'h000};
              default:   arg_n = 32'h0;
            endcase
            phase_n = PH_ISSUE;
          end
          PH_ISSUE: begin
            if (!cmd_busy) begin
              start_n = 1'b1;
              phase_n = PH_WAIT;
            end
          end
          default: begin
            if (fin) begin
              phase_n = PH_SETUP;
              case (state)
                ST_CMD0: state_n = ST_CMD8;
                ST_CMD8: begin
                  if (ok && cmd_resparg[11:0] == 12'h1AA) begin
                    v2_n    = 1'b1;
                    state_n = ST_CMD55;
                  end else if (cmd_timeout) begin
                    v2_n    = 1'b0;
                    state_n = ST_CMD55;
                  end else begin
                    state_n = ST_ERROR;
                  end
                end
                ST_CMD55: begin
                  if (ok)               state_n  = ST_ACMD41;
                  else if (cmd_timeout) do_retry = 1'b1;
                  else                  state_n  = ST_ERROR;
                end
                ST_ACMD41: begin
                  if (ok && cmd_resparg[31]) begin
                    ccs_n   = cmd_resparg[30] & v2;
                    state_n = ST_CMD2;
                  end else if (ok || cmd_timeout) begin
                    do_retry = 1'b1;
                  end else begin
                    state_n = ST_ERROR;
                  end
                end
                ST_CMD2:  state_n = ok ? ST_CMD3 : ST_ERROR;
                ST_CMD3: begin
                  if (ok) begin
                    rca_n   = cmd_resparg[31:16];
                    state_n = ST_CMD7;
                  end else begin
                    state_n = ST_ERROR;
                  end
                end
                ST_CMD7:  state_n = ok ? (ccs ? ST_IDLE : ST_CMD16) : ST_ERROR;
                ST_CMD16: state_n = ok ? ST_IDLE : ST_ERROR;
                ST_CMD17: begin
                  if (ok) begin
                    dat_start_n = 1'b1;
                    state_n     = ST_READ;
                  end else begin
                    rdone_n = 1'b1;
                    rerr_n  = 1'b1;
                    state_n = ST_IDLE;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    endcase

    if (do_retry) begin
      retry_n = retry_inc;
      state_n = (retry_inc >= RETRIES) ? ST_ERROR : ST_CMD55;
    end
    if (state_n != state) phase_n = PH_SETUP;
    if (state_n == ST_IDLE && state != ST_IDLE) begin
      clkdiv_n    = FASTDIV;
      card_type_n = {v2_n, ccs_n | ~v2_n};
    end
    if (state_n == ST_ERROR) card_type_n = CT_UNKNOWN;
    rbusy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb/tb_sd_cmd_seq.sv - Randomized self-checking bench for sd_cmd_seq
module tb_sd_cmd_seq;
  localparam logic [15:0] SLOWDIV = 16'd63;
  localparam logic [15:0] FASTDIV = 16'd1;
  localparam logic [15:0] RETRIES = 16'd6;
  localparam int K_V1 = 0, K_SDSC = 1, K_SDHC = 2;

  logic        clk = 1'b0, rstn = 1'b0, rstart = 1'b0;
  logic [31:0] rsector = '0;
  logic        rbusy, rdone, rerr, cmd_start, dat_start;
  logic [1:0]  card_type;
  logic [3:0]  card_stat;
  logic [15:0] cmd_clkdiv, cmd_precnt;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_busy = 1'b0, cmd_done = 1'b0, cmd_timeout = 1'b0, cmd_syntaxe = 1'b0;
  logic [31:0] cmd_resparg = '0;
  logic        dat_done = 1'b0, dat_err = 1'b0;

  sd_cmd_seq #(.SLOWDIV(SLOWDIV), .FASTDIV(FASTDIV), .RETRIES(RETRIES)) dut (
    .clk(clk), .rstn(rstn), .rstart(rstart), .rsector(rsector),
    .rbusy(rbusy), .rdone(rdone), .rerr(rerr), .card_type(card_type), .card_stat(card_stat),
    .cmd_clkdiv(cmd_clkdiv), .cmd_start(cmd_start), .cmd_precnt(cmd_precnt),
    .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .cmd_timeout(cmd_timeout), .cmd_syntaxe(cmd_syntaxe), .cmd_resparg(cmd_resparg),
    .dat_start(dat_start), .dat_done(dat_done), .dat_err(dat_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, rise_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // card model configuration
  int          kind = K_SDHC, ready_at = 1, t55_left = 0, acmd_tries = 0, dat_mode = 0;
  bit          never_ready = 0, cmd8_bad = 0, cmd17_fail = 0;
  logic [15:0] rca_cfg = 16'h1234;

  logic [5:0]  log_idx[$];
  logic [31:0] log_arg[$];
  logic [15:0] log_pre[$];
  logic [5:0]  exp_idx[$];
  logic [31:0] exp_arg[$];

  logic [5:0]  cap_idx;
  logic [31:0] cap_arg;
  logic [15:0] cap_pre;
  bit          eng_active = 0, prev_start = 0, first_seen = 0;
  int          eng_cnt = 0;
  int          dat_starts = 0, dat_cnt = 0;
  bit          dat_pend = 0;

  task automatic card_respond();
    cmd_resparg = 32'h0;
    case (cap_idx)
      6'd0:  begin acmd_tries = 0; cmd_timeout = 1'($urandom_range(0, 1)); end
      6'd8: begin
        if (kind == K_V1) cmd_timeout = 1'b1;
        else if (cmd8_bad) cmd_resparg = 32'h0000_01A5;
        else cmd_resparg = {20'h0, cap_arg[11:0]};
      end
      6'd55: begin
        if (t55_left > 0) begin t55_left--; cmd_timeout = 1'b1; end
        else cmd_resparg = 32'h0000_0120;
      end
      6'd41: begin
        acmd_tries++;
        if (never_ready || acmd_tries < ready_at) cmd_resparg = 32'h00FF_8000;
        else if (kind == K_SDSC) cmd_resparg = 32'h80FF_8000;
        else cmd_resparg = 32'hC0FF_8000;
      end
      6'd3:  cmd_resparg = {rca_cfg, 16'h0500};
      6'd17: if (cmd17_fail) cmd_timeout = 1'b1;
      default: ;
    endcase
  endtask

  // command engine model
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        eng_active = 0; cmd_busy = 0; cmd_done = 0; cmd_timeout = 0; prev_start = 0;
      end else begin
        cmd_done = 0; cmd_timeout = 0; cmd_syntaxe = 0;
        if (cmd_start) begin
          checks++;
          if (cmd_busy || prev_start) begin
            errors++;
            $display("FAIL start_protocol cmd_start=1 cmd_busy=%b prev_start=%b required both 0", cmd_busy, prev_start);
          end
        end
        if (eng_active) begin
          checks++;
          if (cmd_idx !== cap_idx || cmd_arg !== cap_arg || cmd_precnt !== cap_pre) begin
            errors++;
            $display("FAIL req_stable idx=%0d arg=%h pre=%0d required idx=%0d arg=%h pre=%0d",
                     cmd_idx, cmd_arg, cmd_precnt, cap_idx, cap_arg, cap_pre);
          end
          if (eng_cnt == 0) begin
            card_respond();
            cmd_done = 1; cmd_busy = 0; eng_active = 0;
          end else eng_cnt--;
        end else if (cmd_start && !prev_start) begin
          cap_idx = cmd_idx; cap_arg = cmd_arg; cap_pre = cmd_precnt;
          log_idx.push_back(cmd_idx); log_arg.push_back(cmd_arg); log_pre.push_back(cmd_precnt);
          checks++;
          if (cmd_clkdiv !== ((cmd_idx == 6'd17) ? FASTDIV : SLOWDIV)) begin
            errors++;
            $display("FAIL clkdiv idx=%0d got %0d required %0d", cmd_idx, cmd_clkdiv,
                     (cmd_idx == 6'd17) ? FASTDIV : SLOWDIV);
          end
          if (!first_seen) begin
            first_seen = 1;
            checks++;
            if (cyc - rise_cyc < 2) begin
              errors++;
              $display("FAIL first_start_delay got %0d clocks required >= 2", cyc - rise_cyc);
            end
          end
          eng_active = 1; cmd_busy = 1; eng_cnt = $urandom_range(1, 4);
        end
        prev_start = cmd_start;
      end
    end
  end

  // data receiver model
  initial begin
    forever begin
      @(negedge clk);
      dat_done = 0; dat_err = 0;
      if (!rstn) dat_pend = 0;
      else begin
        if (dat_pend) begin
          if (dat_cnt == 0) begin
            dat_pend = 0;
            case (dat_mode)
              0: dat_done = 1;
              1: begin dat_done = 1; dat_err = 1; end
              2: dat_err = 1;
              default: dat_pend = 1;
            endcase
          end else dat_cnt--;
        end
        if (dat_start) begin dat_starts++; dat_pend = 1; dat_cnt = $urandom_range(1, 5); end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the command list the card should see, from the init rules.
  task automatic build_expected(output logic [1:0] exp_type, output bit exp_err);
    int  r, tries, t55;
    bit  v2;
    exp_idx.delete(); exp_arg.delete();
    exp_idx.push_back(6'd0); exp_arg.push_back(32'h0);
    exp_idx.push_back(6'd8); exp_arg.push_back(32'h1AA);
    exp_err = 0; exp_type = 2'd0;
    if (kind != K_V1 && cmd8_bad) begin exp_err = 1; return; end
    v2 = (kind != K_V1);
    r = 0; tries = 0; t55 = t55_left;
    forever begin
      exp_idx.push_back(6'd55); exp_arg.push_back(32'h0);
      if (t55 > 0) begin
        t55--; r++;
        if (r >= int'(RETRIES)) begin exp_err = 1; return; end
        continue;
      end
      exp_idx.push_back(6'd41); exp_arg.push_back(v2 ? 32'h4010_0000 : 32'h0010_0000);
      tries++;
      if (!never_ready && tries >= ready_at) break;
      r++;
      if (r >= int'(RETRIES)) begin exp_err = 1; return; end
    end
    exp_idx.push_back(6'd2); exp_arg.push_back(32'h0);
    exp_idx.push_back(6'd3); exp_arg.push_back(32'h0);
    exp_idx.push_back(6'd7); exp_arg.push_back({rca_cfg, 16'h0});
    if (kind != K_SDHC) begin exp_idx.push_back(6'd16); exp_arg.push_back(32'd512); end
    exp_type = (kind == K_V1) ? 2'd1 : (kind == K_SDSC) ? 2'd2 : 2'd3;
  endtask

  task automatic test_reset();
    logic [83:0] got, want;
    @(negedge clk);
    rstn = 0; rstart = 0;
    repeat (2) @(negedge clk);
    got  = {cmd_start, cmd_idx, cmd_arg, cmd_precnt, cmd_clkdiv, rbusy, rdone, rerr, dat_start, card_type, card_stat};
    want = {1'b0, 6'd0, 32'd0, 16'd0, SLOWDIV, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_values got %h required %h", got, want);
    end
  endtask

  task automatic release_reset();
    log_idx.delete(); log_arg.delete(); log_pre.delete();
    first_seen = 0;
    @(negedge clk);
    rstn = 1; rise_cyc = cyc;
  endtask

  task automatic test_init(input int k, input int ready, input int t55, input bit nr,
                           input bit bad, input bit poke);
    logic [1:0] exp_type;
    bit         exp_err;
    int         n;
    kind = k; ready_at = ready; t55_left = t55; never_ready = nr; cmd8_bad = bad;
    cmd17_fail = 0; acmd_tries = 0; rca_cfg = 16'($urandom);
    test_reset();
    build_expected(exp_type, exp_err);
    release_reset();
    n = 0;
    forever begin
      @(negedge clk); n++;
      if (card_stat == 4'd8 || card_stat == 4'd11 || n >= 5000) break;
      if (poke) begin rstart = ($urandom_range(0, 3) == 0); rsector = $urandom; end
    end
    rstart = 0;
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL init_timeout card_stat=%0d required 8 or 11", card_stat); end
    checks++;
    if ({card_stat, card_type, rbusy, cmd_clkdiv} !==
        {exp_err ? 4'd11 : 4'd8, exp_type, exp_err, exp_err ? SLOWDIV : FASTDIV}) begin
      errors++;
      $display("FAIL init_result stat=%0d type=%0d rbusy=%b clkdiv=%0d required stat=%0d type=%0d rbusy=%b clkdiv=%0d",
               card_stat, card_type, rbusy, cmd_clkdiv, exp_err ? 11 : 8, exp_type, exp_err,
               exp_err ? SLOWDIV : FASTDIV);
    end
    checks++;
    if (log_idx.size() != exp_idx.size()) begin
      errors++;
      $display("FAIL init_cmd_count got %0d required %0d", log_idx.size(), exp_idx.size());
    end
    for (int i = 0; i < exp_idx.size() && i < log_idx.size(); i++) begin
      checks++;
      if (log_idx[i] !== exp_idx[i] || log_arg[i] !== exp_arg[i]) begin
        errors++;
        $display("FAIL init_cmd[%0d] got idx=%0d arg=%h required idx=%0d arg=%h",
                 i, log_idx[i], log_arg[i], exp_idx[i], exp_arg[i]);
        break;
      end
    end
    if (log_pre.size() >= 2) begin
      checks++;
      if (log_pre[0] !== 16'd96 || log_pre[1] !== 16'd8) begin
        errors++;
        $display("FAIL precnt got %0d,%0d required 96,8", log_pre[0], log_pre[1]);
      end
    end
  endtask

  task automatic test_read(input logic [31:0] sector, input int mode, input bit fail17,
                           input bit ccs, input bit tight);
    int          n, n0, nlog;
    logic [31:0] exp_a;
    dat_mode = mode; cmd17_fail = fail17;
    n0 = dat_starts; nlog = log_idx.size();
    exp_a = ccs ? sector : sector * 32'd512;
    if (!tight) @(negedge clk);
    rstart = 1; rsector = sector;
    @(negedge clk);
    rstart = 0; rsector = $urandom;
    checks++;
    if (rbusy !== 1'b1) begin errors++; $display("FAIL read_busy got %b required 1", rbusy); end
    n = 0;
    while (rdone !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL read_timeout rdone=%b required 1", rdone); end
    checks++;
    if (rerr !== (mode != 0 || fail17)) begin
      errors++; $display("FAIL read_rerr got %b required %b", rerr, (mode != 0 || fail17));
    end
    checks++;
    if (log_idx.size() != nlog + 1 || log_idx[log_idx.size()-1] !== 6'd17 ||
        log_arg[log_arg.size()-1] !== exp_a) begin
      errors++;
      $display("FAIL read_cmd17 got count=%0d idx=%0d arg=%h required count=%0d idx=17 arg=%h",
               log_idx.size() - nlog, log_idx[log_idx.size()-1], log_arg[log_arg.size()-1], 1, exp_a);
    end
    checks++;
    if (dat_starts - n0 != (fail17 ? 0 : 1)) begin
      errors++; $display("FAIL dat_start_pulses got %0d required %0d", dat_starts - n0, fail17 ? 0 : 1);
    end
    @(negedge clk);
    checks++;
    if ({rdone, rbusy} !== 2'b00) begin
      errors++; $display("FAIL rdone_pulse got rdone=%b rbusy=%b required 0 0", rdone, rbusy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      int m;
      m = $urandom_range(0, 2);
      test_read($urandom, m, ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
    end
  endtask

  task automatic test_never_ready();
    int n41, nlog;
    test_init(K_SDSC, 1, 0, 1'b1, 1'b0, 1'b1);
    n41 = 0;
    foreach (log_idx[i]) if (log_idx[i] == 6'd41) n41++;
    checks++;
    if (n41 != int'(RETRIES)) begin
      errors++; $display("FAIL acmd41_issues got %0d required %0d", n41, RETRIES);
    end
    nlog = log_idx.size();
    repeat (30) @(negedge clk);
    checks++;
    if ({card_stat, rbusy, card_type} !== {4'd11, 1'b1, 2'd0} || log_idx.size() != nlog) begin
      errors++;
      $display("FAIL error_terminal stat=%0d rbusy=%b type=%0d new_cmds=%0d required 11 1 0 0",
               card_stat, rbusy, card_type, log_idx.size() - nlog);
    end
  endtask

  task automatic test_reset_during_read();
    int n;
    test_init(K_SDHC, 2, 0, 1'b0, 1'b0, 1'b0);
    dat_mode = 3; cmd17_fail = 0;
    @(negedge clk); rstart = 1; rsector = $urandom;
    @(negedge clk); rstart = 0;
    n = 0;
    while (card_stat != 4'd10 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (card_stat !== 4'd10) begin errors++; $display("FAIL reach_read got %0d required 10", card_stat); end
    test_reset();
    release_reset();
    n = 0;
    while (log_idx.size() == 0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (log_idx.size() == 0 || log_idx[0] !== 6'd0) begin
      errors++; $display("FAIL restart_cmd0 got count=%0d required first cmd idx 0", log_idx.size());
    end
    dat_mode = 0;
  endtask

  initial begin
    test_reset();
    test_init(K_SDHC, 3, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) test_read($urandom, 0, 1'b0, 1'b1, 1'b0);
    test_init(K_V1, $urandom_range(1, 3), 1, 1'b0, 1'b0, 1'b0);
    test_read($urandom, 0, 1'b0, 1'b0, 1'b0);
    test_init(K_SDSC, $urandom_range(1, 4), 0, 1'b0, 1'b0, 1'b1);
    test_read(32'h0080_0001, 0, 1'b0, 1'b0, 1'b0);
    test_back_to_back();
    test_never_ready();
    test_init(K_SDSC, 1, 0, 1'b0, 1'b1, 1'b0);
    test_reset_during_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
